// File: rtl/gpt_pkg.sv
// Shared types for the general-purpose timer channels: prescaler and polarity
// encodings plus the prescaler terminal-count helper.
package gpt_pkg;

   localparam int PRE_W = 3;

   typedef enum logic [1:0] {
      DIV1 = 2'b00,
      DIV2 = 2'b01,
      DIV4 = 2'b10,
      DIV8 = 2'b11
   } icps_e;

   typedef enum logic [1:0] {
      RISE = 2'b00,
      FALL = 2'b01,
      RSVD = 2'b10,
      BOTH = 2'b11
   } ccp_e;

   // Terminal count of the event counter, i.e. divisor - 1.
   function automatic logic [PRE_W-1:0] icps_last(input icps_e ps);
      case (ps)
         DIV1:    return 3'd0;
         DIV2:    return 3'd1;
         DIV4:    return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/ic_input_filter.sv
// Timer pin front end: synchroniser, post-reset priming window and a
// stability filter that only follows the pin after it has settled.
module ic_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4
) (
   input  logic              clk_i,
   input  logic              aresetn_i,
   input  logic [FILT_W-1:0] icf_i,
   input  logic              tim_i,
   output logic              sync_o,
   output logic              filt_o,
   output logic              valid_o
);

   localparam int PRIME = SYNC_STAGES + 1;
   localparam int PW    = $clog2(PRIME + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [PW-1:0]          prime_q, prime_d;
   logic [FILT_W-1:0]      stab_q, stab_d;
   logic [FILT_W-1:0]      icf_q;
   logic                   filt_q, filt_d;
   logic                   sync, primed;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign primed = (prime_q == PW'(PRIME));

   // The level must disagree for icf_i counted cycles and then once more
   // before it is accepted; a reprogrammed length restarts the count.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], tim_i};
      prime_d = prime_q;
      filt_d  = filt_q;
      stab_d  = '0;
      if (!primed) begin
         prime_d = prime_q + PW'(1);
         filt_d  = sync;
      end else if (icf_i == '0) begin
         filt_d = sync;
      end else if (icf_i == icf_q && sync != filt_q) begin
         if (stab_q == icf_i) filt_d = sync;
         else                 stab_d = stab_q + FILT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!aresetn_i) begin
         sync_q  <= '0;
         prime_q <= '0;
         stab_q  <= '0;
         icf_q   <= '0;
         filt_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prime_q <= prime_d;
         stab_q  <= stab_d;
         icf_q   <= icf_i;
         filt_q  <= filt_d;
      end
   end

   assign sync_o  = sync;
   assign filt_o  = filt_q;
   assign valid_o = primed;

endmodule

// File: rtl/input_capture_channel.sv
// Timer input-capture channel: qualified edge detection, event prescaler,
// capture register and sticky capture/overcapture flags.
module input_capture_channel
   import gpt_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4
) (
   input  logic              clk_i,
   input  logic              aresetn_i,
   input  logic              cce_i,
   input  logic [1:0]        icps_i,
   input  logic [1:0]        ccp_i,
   input  logic [FILT_W-1:0] icf_i,
   input  logic              tim_i,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic              flag_clr_i,
   output logic [CNT_W-1:0]  ccr_o,
   output logic              ccif_o,
   output logic              ccof_o,
   output logic              cap_pulse_o
);

   logic             sync, filt, valid;
   logic             prev_q, prev_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [1:0]       icps_q;
   logic [CNT_W-1:0] ccr_q, ccr_d;
   logic             ccif_q, ccif_d, ccof_q, ccof_d, cap_q;
   logic             rise, fall, edge_sel, evt, cap;

   ic_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
   ) u_filter (
      .clk_i     (clk_i),
      .aresetn_i (aresetn_i),
      .icf_i     (icf_i),
      .tim_i     (tim_i),
      .sync_o    (sync),
      .filt_o    (filt),
      .valid_o   (valid)
   );

   always_comb begin
      rise = filt & ~prev_q;
      fall = ~filt & prev_q;
      case (ccp_e'(ccp_i))
         FALL:    edge_sel = fall;
         BOTH:    edge_sel = rise | fall;
         default: edge_sel = rise;
      endcase
      evt = valid & cce_i & edge_sel;
      cap = evt & (pre_q == icps_last(icps_e'(icps_i)));

      if (!cce_i || icps_i != icps_q) pre_d = '0;
      else if (cap)                   pre_d = '0;
      else if (evt)                   pre_d = pre_q + PRE_W'(1);
      else                            pre_d = pre_q;

      // While priming, the previous level follows the synchroniser so a pin
      // already high at reset release never looks like an edge.
      prev_d = valid ? filt : sync;
      ccr_d  = cap ? cnt_i : ccr_q;
      ccif_d = cap | (ccif_q & ~flag_clr_i);
      ccof_d = ~flag_clr_i & (ccof_q | (cap & ccif_q));
   end

   always_ff @(posedge clk_i) begin
      if (!aresetn_i) begin
         prev_q <= 1'b0;
         pre_q  <= '0;
         icps_q <= '0;
         ccr_q  <= '0;
         ccif_q <= 1'b0;
         ccof_q <= 1'b0;
         cap_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         pre_q  <= pre_d;
         icps_q <= icps_i;
         ccr_q  <= ccr_d;
         ccif_q <= ccif_d;
         ccof_q <= ccof_d;
         cap_q  <= cap;
      end
   end

   assign ccr_o       = ccr_q;
   assign ccif_o      = ccif_q;
   assign ccof_o      = ccof_q;
   assign cap_pulse_o = cap_q;

endmodule
